// File: rtl/word_half_serializer_pkg.sv
// Shared widths, FSM state encoding and a small helper for the word-to-halfword serializer.
package word_half_serializer_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_LAST  = 2'd2
    } state_t;

    // A word whose upper half is zero is a zero-extended halfword.
    function automatic logic is_zero_ext(input logic [WORD_W-1:0] word);
        return (word[WORD_W-1:HALF_W] == 16'h0000);
    endfunction

endpackage

// File: rtl/word_half_serializer_half_select.sv
// Picks the halfword of a word to present for a given beat phase and half ordering.
module word_half_serializer_half_select
    import word_half_serializer_pkg::*;
#(
    parameter int LOW_FIRST = 1
) (
    input  logic [WORD_W-1:0] word,
    input  logic              phase,
    output logic [HALF_W-1:0] half
);

    logic take_low_s;

    // Low half goes out on the first beat when LOW_FIRST is set, otherwise on the second.
    always_comb begin
        take_low_s = 1'b0;
        if (LOW_FIRST != 0) begin
            take_low_s = (phase == 1'b0);
        end else begin
            take_low_s = (phase == 1'b1);
        end
        if (take_low_s) begin
            half = word[HALF_W-1:0];
        end else begin
            half = word[WORD_W-1:HALF_W];
        end
    end

endmodule

// File: rtl/word_half_serializer.sv
// Serializes 32-bit words into 16-bit beats with valid/ready on both sides,
// optionally sending zero-extended words as a single beat.
module word_half_serializer
    import word_half_serializer_pkg::*;
#(
    parameter int LOW_FIRST = 1,
    parameter int COMPRESS  = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HALF_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  words_done
);

    state_t              state_r;
    logic [WORD_W-1:0]   hold_r;
    logic                out_valid_r;
    logic [HALF_W-1:0]   out_data_r;
    logic                out_last_r;
    logic [CNT_W-1:0]    words_done_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                compress_s;
    logic [WORD_W-1:0]   sel_word_s;
    logic                sel_phase_s;
    logic [HALF_W-1:0]   sel_half_s;

    // Ready and accept decode; a finishing LAST beat frees the slot in the same cycle.
    always_comb begin
        in_ready_s = rst_n && ((state_r == ST_IDLE) || ((state_r == ST_LAST) && out_ready));
        accept_s   = in_valid && in_ready_s;
        compress_s = (COMPRESS != 0) && is_zero_ext(in_data);
    end

    // The single half selector serves both the incoming word's first beat and the held word's second.
    always_comb begin
        sel_word_s  = hold_r;
        sel_phase_s = 1'b1;
        if (accept_s) begin
            sel_word_s  = in_data;
            sel_phase_s = 1'b0;
        end else begin
            sel_word_s  = hold_r;
            sel_phase_s = 1'b1;
        end
    end

    word_half_serializer_half_select #(
        .LOW_FIRST (LOW_FIRST)
    ) u_half_select (
        .word  (sel_word_s),
        .phase (sel_phase_s),
        .half  (sel_half_s)
    );

    // Serializer FSM with registered beat outputs and completed-word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            hold_r       <= 32'h0000_0000;
            out_valid_r  <= 1'b0;
            out_data_r   <= 16'h0000;
            out_last_r   <= 1'b0;
            words_done_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_LAST: begin
                    if ((state_r == ST_LAST) && out_ready) begin
                        words_done_r <= words_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (accept_s) begin
                        hold_r      <= in_data;
                        out_valid_r <= 1'b1;
                        if (compress_s) begin
                            state_r    <= ST_LAST;
                            out_data_r <= in_data[HALF_W-1:0];
                            out_last_r <= 1'b1;
                        end else begin
                            state_r    <= ST_FIRST;
                            out_data_r <= sel_half_s;
                            out_last_r <= 1'b0;
                        end
                    end else if ((state_r == ST_LAST) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FIRST: begin
                    if (out_ready) begin
                        state_r    <= ST_LAST;
                        out_data_r <= sel_half_s;
                        out_last_r <= 1'b1;
                    end else begin
                        state_r <= ST_FIRST;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign words_done = words_done_r;

endmodule

// File: tb/tb_word_half_serializer.sv
// Directed self-checking bench: a low-first compressing instance and a high-first plain instance.
module tb_word_half_serializer;

    logic        clk;
    logic        rst_n;

    logic        in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic [7:0]  words_done;

    logic        in_valid2, out_ready2;
    logic [31:0] in_data2;
    logic        in_ready2, out_valid2, out_last2;
    logic [15:0] out_data2;
    logic [7:0]  words_done2;

    int compared;
    int mismatched;

    word_half_serializer #(.LOW_FIRST(1), .COMPRESS(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .words_done(words_done)
    );

    word_half_serializer #(.LOW_FIRST(0), .COMPRESS(0), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_last(out_last2), .words_done(words_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = 32'h0000_0000;
        out_ready2 = 1'b1;

        // Reset held three cycles with a word offered.
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_words_done", {24'd0, words_done}, 32'd0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Uncompressed word, low half first.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        #1;
        check("w1_b0_valid", {31'd0, out_valid}, 32'd1);
        check("w1_b0_data", {16'd0, out_data}, 32'h0000_BEEF);
        check("w1_b0_last", {31'd0, out_last}, 32'd0);
        check("w1_b0_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        check("w1_b1_data", {16'd0, out_data}, 32'h0000_DEAD);
        check("w1_b1_last", {31'd0, out_last}, 32'd1);
        step();
        #1;
        check("w1_idle_valid", {31'd0, out_valid}, 32'd0);
        check("w1_words_done", {24'd0, words_done}, 32'd1);

        // Back-to-back compressed words followed by a two-beat word.
        in_valid = 1'b1;
        in_data  = 32'h0000_1234;
        #1;
        check("c_in_ready0", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 32'h0000_5678;
        #1;
        check("c1_data", {16'd0, out_data}, 32'h0000_1234);
        check("c1_last", {31'd0, out_last}, 32'd1);
        check("c1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 32'hCAFE_0001;
        #1;
        check("c2_data", {16'd0, out_data}, 32'h0000_5678);
        check("c2_last", {31'd0, out_last}, 32'd1);
        check("c2_valid", {31'd0, out_valid}, 32'd1);
        check("c2_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("c3a_data", {16'd0, out_data}, 32'h0000_0001);
        check("c3a_last", {31'd0, out_last}, 32'd0);
        check("c3a_in_ready", {31'd0, in_ready}, 32'd0);
        check("c3a_words_done", {24'd0, words_done}, 32'd3);
        step();
        #1;
        check("c3b_data", {16'd0, out_data}, 32'h0000_CAFE);
        check("c3b_last", {31'd0, out_last}, 32'd1);
        check("c3b_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        #1;
        check("c_idle_valid", {31'd0, out_valid}, 32'd0);
        check("c_words_done", {24'd0, words_done}, 32'd4);

        // Backpressure on the first beat; a competing word must not be captured.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        out_ready = 1'b0;
        in_data   = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_data", {16'd0, out_data}, 32'h0000_BEEF);
            check("bp_last", {31'd0, out_last}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        #1;
        check("bp_b1_data", {16'd0, out_data}, 32'h0000_DEAD);
        check("bp_b1_last", {31'd0, out_last}, 32'd1);
        step();
        #1;
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        check("bp_words_done", {24'd0, words_done}, 32'd5);

        // High half first, no compression.
        in_valid2 = 1'b1;
        in_data2  = 32'h0000_00FF;
        step();
        in_valid2 = 1'b0;
        #1;
        check("hf_b0_valid", {31'd0, out_valid2}, 32'd1);
        check("hf_b0_data", {16'd0, out_data2}, 32'h0000_0000);
        check("hf_b0_last", {31'd0, out_last2}, 32'd0);
        step();
        #1;
        check("hf_b1_data", {16'd0, out_data2}, 32'h0000_00FF);
        check("hf_b1_last", {31'd0, out_last2}, 32'd1);
        step();
        #1;
        check("hf_idle_valid", {31'd0, out_valid2}, 32'd0);
        check("hf_words_done", {24'd0, words_done2}, 32'd1);

        // Reset while the first beat of a word is presented.
        in_valid  = 1'b1;
        in_data   = 32'h1111_2222;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        check("mr_b0_data", {16'd0, out_data}, 32'h0000_2222);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_words_done", {24'd0, words_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("mr_no_beat", {31'd0, out_valid}, 32'd0);
        end

        // 256 compressed words streamed back to back wrap the counter.
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 32'(i);
            step();
            if (i == 128) begin
                #1;
                check("wrap_mid_data", {16'd0, out_data}, 32'h0000_0080);
                check("wrap_mid_done", {24'd0, words_done}, 32'd128);
            end
        end
        in_valid = 1'b0;
        #1;
        check("wrap_last_data", {16'd0, out_data}, 32'h0000_00FF);
        check("wrap_pre_done", {24'd0, words_done}, 32'd255);
        step();
        #1;
        check("wrap_done", {24'd0, words_done}, 32'd0);
        check("wrap_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/word_half_serializer.md
Name: word_half_serializer

Overview:
- Narrows 32-bit words into a stream of 16-bit halfwords. It is the inverse of our 16→32 zero-extender.
- Sits between the 32-bit datapath and 16-bit-wide consumers, such as the halfword store path and the narrow debug/trace port.
- Uses valid/ready handshakes on both sides.
- Optionally compresses words whose upper half is zero (i.e. zero-extended values) into a single halfword beat.

Parameters:
- LOW_FIRST, 1, 1 = emit bits [15:0] first then [31:16]; 0 = high half first.
- COMPRESS, 1, 1 = a word with in_data[31:16]==0 is sent as one beat (low half only); 0 = always two beats.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  producer presents a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  word to serialize
- out_valid  output  1  out_data/out_last valid
- out_ready  input  1  consumer accepts the current beat
- out_data  output  16  halfword beat
- out_last  output  1  final beat of the current word
- words_done  output  CNT_W  count of fully transmitted words, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n sampled low at a clock edge):
  - state=IDLE; out_valid=0, out_data=0, out_last=0, words_done=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-word discards the held word; no partial beat appears afterwards.
- States:
  - IDLE: no word held.
  - FIRST: first beat of a two-beat word presented.
  - LAST: final beat presented (second half, or the single compressed beat).
- in_ready (combinational) = rst_n && (state==IDLE || (state==LAST && out_ready)).
- Accept: occurs when in_valid && in_ready. in_data is captured into a 32-bit hold register at that edge.
- Beat selection on accept:
  - Compressed (COMPRESS=1 and in_data[31:16]==0): next state=LAST, out_data=in_data[15:0], out_last=1.
  - Otherwise: next state=FIRST, out_data=first half per LOW_FIRST, out_last=0.
- Latency and throughput:
  - First beat is registered: out_valid rises the cycle after accept.
  - Max throughput is 2 cycles/word uncompressed and 1 cycle/word compressed.
- FIRST transitions:
  - out_ready=1 → LAST, out_data=other half, out_last=1.
  - out_ready=0 → hold all outputs unchanged.
- LAST transitions:
  - out_ready=1 with a new accept the same cycle → load the new word per the accept rules (no bubble).
  - out_ready=1 with no accept → IDLE, out_valid=0.
  - out_ready=0 → hold.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_last and out_valid must not change.
- words_done: increments by 1 on each handshake with out_last=1; wraps from 2^CNT_W-1 to 0.
- Input side rules:
  - in_valid with in_ready=0 is ignored; nothing is captured.
  - in_data is don't-care when in_valid=0.
- out_data keeps its last value when out_valid=0. Verification checks out_data only while out_valid=1.

Decomposition:
- Shared package holds:
  - WORD_W=32, HALF_W=16.
  - State encoding constants ST_IDLE, ST_FIRST, ST_LAST (2 bits).
- Sub-module half_select (combinational): inputs word[31:0], phase (0=first,1=second) and LOW_FIRST; outputs the selected 16-bit half. Instantiated once by the FSM.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 cycles, with in_valid=1 → out_valid=0, in_ready=0, words_done=0 throughout. After release, in_ready=1 in the first cycle.
- Uncompressed word, LOW_FIRST=1, out_ready=1: send 0xDEAD_BEEF → beats 0xBEEF (last=0) then 0xDEAD (last=1) on consecutive cycles; words_done=1.
- Compression and back-to-back: COMPRESS=1, stream 0x0000_1234, 0x0000_5678, 0xCAFE_0001 with in_valid held high →
  - beats 0x1234/L, 0x5678/L, 0x0001, 0xCAFE/L;
  - no bubbles; in_ready low exactly 1 cycle during the third word;
  - words_done=3.
- Backpressure: during the 0xBEEF beat, hold out_ready=0 for 4 cycles → out_data=0xBEEF and out_last=0 stable, in_ready=0, with a new in_valid=1 not captured. After release, 0xDEAD/L follows.
- LOW_FIRST=0, COMPRESS=0: send 0x0000_00FF → beats 0x0000 (last=0) then 0x00FF (last=1).
- Reset mid-word and counter wrap:
  - rst_n=0 for one cycle while the FIRST beat of 0x1111_2222 is presented → next cycle out_valid=0, no 0x1111 beat ever, words_done=0.
  - Separately, 256 compressed words → words_done wraps to 0.
